// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-requester RAM arbiter: requester port id, the
// read-return tag, and the default address width.
package saratoga;

  localparam int NUM_RAM_REQ            = 2;
  localparam int DEFAULT_RAM_ADDR_WIDTH = 10;

  typedef logic [$clog2(NUM_RAM_REQ)-1:0] arb_port_t;

  localparam arb_port_t PORT_M0 = 1'b0;  // core DBus
  localparam arb_port_t PORT_M1 = 1'b1;  // debug / DMA

  // Destination of the read issued in the previous cycle.
  typedef struct packed {
    logic      valid;
    arb_port_t port;
  } pend_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester and RAM-side signals for ram_arbiter. The arbiter uses
// the slave modport; requesters plus the RAM use the master modport.
interface ram_arbiter_if
  import saratoga::*;
#(
  parameter int ADDR_WIDTH      = DEFAULT_RAM_ADDR_WIDTH,
  parameter int STALL_CNT_WIDTH = 16
);
  logic                       m0_rd_en, m0_wr_en, m0_busy, m0_rd_valid;
  logic [ADDR_WIDTH-1:0]      m0_addr;
  logic [31:0]                m0_wr_data, m0_rd_data;
  logic [3:0]                 m0_wr_strobe;

  logic                       m1_rd_en, m1_wr_en, m1_busy, m1_rd_valid;
  logic [ADDR_WIDTH-1:0]      m1_addr;
  logic [31:0]                m1_wr_data, m1_rd_data;
  logic [3:0]                 m1_wr_strobe;

  logic                       ram_rd_en, ram_wr_en;
  logic [ADDR_WIDTH-1:0]      ram_addr;
  logic [31:0]                ram_wr_data, ram_rd_data;
  logic [3:0]                 ram_wr_strobe;

  logic [STALL_CNT_WIDTH-1:0] conflict_count;

  modport slave (
    input  m0_rd_en, m0_wr_en, m0_addr, m0_wr_data, m0_wr_strobe,
    input  m1_rd_en, m1_wr_en, m1_addr, m1_wr_data, m1_wr_strobe,
    input  ram_rd_data,
    output m0_busy, m0_rd_data, m0_rd_valid,
    output m1_busy, m1_rd_data, m1_rd_valid,
    output ram_rd_en, ram_wr_en, ram_addr, ram_wr_data, ram_wr_strobe,
    output conflict_count
  );

  modport master (
    output m0_rd_en, m0_wr_en, m0_addr, m0_wr_data, m0_wr_strobe,
    output m1_rd_en, m1_wr_en, m1_addr, m1_wr_data, m1_wr_strobe,
    output ram_rd_data,
    input  m0_busy, m0_rd_data, m0_rd_valid,
    input  m1_busy, m1_rd_data, m1_rd_valid,
    input  ram_rd_en, ram_wr_en, ram_addr, ram_wr_data, ram_wr_strobe,
    input  conflict_count
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way combinational arbiter. Build with RAM_ARB_RR_EN for round-robin
// (last_grant state); otherwise port 0 has fixed priority and no state exists.
module rr_arb2
  import saratoga::*;
(
`ifdef RAM_ARB_RR_EN
  input  logic                   clk,
  input  logic                   rst_n,
`endif
  input  logic [NUM_RAM_REQ-1:0] req,
  output logic                   gnt_valid,
  output arb_port_t              gnt_port
);

`ifdef RAM_ARB_RR_EN
  arb_port_t last_grant;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt_valid = |req;
    gnt_port  = PORT_M0;
    if (&req)       gnt_port = (last_grant == PORT_M0) ? PORT_M1 : PORT_M0;
    else if (req[1]) gnt_port = PORT_M1;
  end

  // Reset to port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_grant <= PORT_M1;
    else if (gnt_valid) last_grant <= gnt_port;
  end
`else
  always_comb begin
    gnt_valid = |req;
    gnt_port  = (!req[0] && req[1]) ? PORT_M1 : PORT_M0;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one synchronous single-port RAM and routes
// read data back one cycle later. Optional macro: RAM_ARB_RR_EN (round-robin).
module ram_arbiter
  import saratoga::*;
#(
  parameter int ADDR_WIDTH      = DEFAULT_RAM_ADDR_WIDTH,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  logic [NUM_RAM_REQ-1:0]     req;
  logic                       gnt_valid, sel_m1, sel_rd, sel_wr;
  arb_port_t                  gnt_port;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [31:0]                sel_wr_data;
  logic [3:0]                 sel_wr_strobe;
  pend_tag_t                  pend;
  logic [STALL_CNT_WIDTH-1:0] conflict_cnt;

  assign req = {bus.m1_rd_en | bus.m1_wr_en, bus.m0_rd_en | bus.m0_wr_en};

  rr_arb2 u_arb (
`ifdef RAM_ARB_RR_EN
    .clk       (clk),
    .rst_n     (rst_n),
`endif
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  // With no grant the mux falls back to m0, which keeps the idle bus quiet.
  assign sel_m1 = gnt_valid && (gnt_port == PORT_M1);

  always_comb begin
    sel_addr      = sel_m1 ? bus.m1_addr      : bus.m0_addr;
    sel_wr_data   = sel_m1 ? bus.m1_wr_data   : bus.m0_wr_data;
    sel_wr_strobe = sel_m1 ? bus.m1_wr_strobe : bus.m0_wr_strobe;
    sel_wr        = sel_m1 ? bus.m1_wr_en     : bus.m0_wr_en;
    sel_rd        = sel_m1 ? (bus.m1_rd_en & ~bus.m1_wr_en)
                           : (bus.m0_rd_en & ~bus.m0_wr_en);
  end

  assign bus.ram_rd_en     = gnt_valid & sel_rd;
  assign bus.ram_wr_en     = gnt_valid & sel_wr;
  assign bus.ram_addr      = sel_addr;
  assign bus.ram_wr_data   = sel_wr_data;
  assign bus.ram_wr_strobe = sel_wr_strobe;

  assign bus.m0_busy = req[0] & (gnt_port != PORT_M0);
  assign bus.m1_busy = req[1] & (gnt_port != PORT_M1);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend         <= '0;
      conflict_cnt <= '0;
    end else begin
      pend.valid <= bus.ram_rd_en;
      pend.port  <= gnt_port;
      if (&req && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  assign bus.m0_rd_valid = pend.valid && (pend.port == PORT_M0);
  assign bus.m1_rd_valid = pend.valid && (pend.port == PORT_M1);
  assign bus.m0_rd_data  = bus.m0_rd_valid ? bus.ram_rd_data : '0;
  assign bus.m1_rd_data  = bus.m1_rd_valid ? bus.ram_rd_data : '0;

  assign bus.conflict_count = conflict_cnt;

endmodule
